mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the five-stage core. It runs one outstanding transaction at a time through a request/grant/response FSM. It gives data accesses priority, with a starvation guard for fetch. It drives stall_f and stall_m to the hazard logic, and the pipeline holds its IF and MEM registers while these are high.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/arb_starve_ctr.sv | 29 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter: FSM states and the
// owner of the transaction being started.
package mem_port_arbiter_pkg;

   typedef logic [2:0] arbState_t;

   localparam arbState_t IDLE  = 3'd0;
   localparam arbState_t REQ_I = 3'd1;
   localparam arbState_t REQ_D = 3'd2;
   localparam arbState_t RSP_I = 3'd3;
   localparam arbState_t RSP_D = 3'd4;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch waits; one-cycle update,
// clr wins over inc, atMax is a combinational decode of the count.
module arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic atMax
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] cnt;

   assign atMax = (cnt == CW'(STARVE_MAX));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !atMax) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data, one transaction at a time; 3 cycles
// request to pulse with zero-wait memory, stalls held until the pulse. MEMARB_PERF_CNT_EN adds the conflict counter.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              flush_f,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_f,
   output logic              stall_m,
   output logic [31:0]       conflict_cnt
);

   arbState_t state;
   logic      drop;
   logic      starveMax;
   logic      ifPend;
   logic      dmPend;
   logic      fetchWin;
   logic      dataWin;
   logic      grantOwn;

   // A requester whose pulse is out this cycle still has its request high; mask it.
   assign ifPend   = if_req & ~if_rvalid & ~flush_f;
   assign dmPend   = dm_req & ~dm_done;
   assign fetchWin = (state == IDLE) & ifPend & (~dm_req | starveMax);
   assign dataWin  = (state == IDLE) & ~fetchWin & dmPend;
   assign grantOwn = fetchWin ? OWN_I : OWN_D;

   assign stall_f = ifPend;
   assign stall_m = dmPend;

   arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) uStarveCtr (
      .clk  (clk),
      .reset(reset),
      .inc  (dataWin & if_req),
      .clr  (fetchWin | ~if_req),
      .atMax(starveMax)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         drop      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         dm_done   <= 1'b0;
         dm_rdata  <= '0;
      end else begin
         if_rvalid <= 1'b0;
         dm_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (fetchWin || dataWin) begin
                  mem_req <= 1'b1;
                  if (grantOwn == OWN_I) begin
                     state    <= REQ_I;
                     mem_addr <= if_addr;
                     mem_we   <= 1'b0;
                  end else begin
                     state     <= REQ_D;
                     mem_addr  <= dm_addr;
                     mem_we    <= dm_we;
                     mem_wdata <= dm_wdata;
                  end
               end
            end
            REQ_I: begin
               if (mem_gnt) begin
                  state   <= RSP_I;
                  mem_req <= 1'b0;
                  drop    <= flush_f;
               end else if (flush_f) begin
                  // Withdrawn before acceptance: memory never saw it.
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            REQ_D: begin
               if (mem_gnt) begin
                  state   <= RSP_D;
                  mem_req <= 1'b0;
               end
            end
            RSP_I: begin
               if (mem_rvalid) begin
                  state <= IDLE;
                  drop  <= 1'b0;
                  if (!(drop || flush_f)) begin
                     if_rdata  <= mem_rdata;
                     if_rvalid <= 1'b1;
                  end
               end else if (flush_f) begin
                  drop <= 1'b1;
               end
            end
            RSP_D: begin
               if (mem_rvalid) begin
                  state   <= IDLE;
                  dm_done <= 1'b1;
                  if (!mem_we) begin
                     dm_rdata <= mem_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEMARB_PERF_CNT_EN
   logic [31:0] conflictReg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         conflictReg <= '0;
      end else if (if_req && dm_req && !(&conflictReg)) begin
         conflictReg <= conflictReg + 32'd1;
      end
   end

   assign conflict_cnt = conflictReg;
`else
   assign conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter against a zero/variable-wait memory model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, flush_f, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_done;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall_f, stall_m;
   logic [31:0] conflict_cnt;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .flush_f(flush_f),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_done(dm_done), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall_f(stall_f), .stall_m(stall_m), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // Memory model: grant gated by gntEn, response rspDelay cycles after the
   // cycle following the grant, read data = addr ^ 0xCAFE0000.
   logic        gntEn = 1'b1;
   logic [3:0]  rspDelay = 4'd0;
   logic        rspPend;
   logic [3:0]  rspWait;
   logic [31:0] rdAddr;
   logic [31:0] grantLog[$];
   logic [31:0] confModel;
   logic [31:0] expConflict;

   assign mem_gnt    = mem_req & gntEn;
   assign mem_rvalid = rspPend && (rspWait == 4'd0);
   assign mem_rdata  = rdAddr ^ 32'hCAFE0000;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         rspPend <= 1'b0;
         rspWait <= 4'd0;
         rdAddr  <= 32'd0;
      end else if (mem_req && mem_gnt) begin
         rspPend <= 1'b1;
         rspWait <= rspDelay;
         rdAddr  <= mem_addr;
      end else if (rspPend) begin
         if (rspWait == 4'd0) rspPend <= 1'b0;
         else rspWait <= rspWait - 4'd1;
      end
   end

   always @(posedge clk) begin
      if (reset && mem_req && mem_gnt) grantLog.push_back(mem_addr);
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) confModel <= 32'd0;
      else if (if_req && dm_req && confModel != 32'hFFFFFFFF) confModel <= confModel + 32'd1;
   end

`ifdef MEMARB_PERF_CNT_EN
   assign expConflict = confModel;
`else
   assign expConflict = 32'd0;
`endif

   int nTests = 0;
   int nFail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic waitPulse(input bit forData, output int cycles);
      cycles = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (forData ? dm_done : if_rvalid) begin
            cycles = c;
            break;
         end
      end
   endtask

   function automatic logic [31:0] logAt(input int idx);
      if (idx < grantLog.size()) return grantLog[idx];
      return 32'hxxxxxxxx;
   endfunction

   typedef struct {
      bit          isData;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
   } vec_t;

   vec_t        vecs[4];
   logic [31:0] starvePat[10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, start, cyc, pulses;
      bit stopping;

      vecs[0] = '{isData: 1'b0, we: 1'b0, addr: 32'h100, wdata: 32'h0,        expRdata: 32'hCAFE0100};
      vecs[1] = '{isData: 1'b1, we: 1'b0, addr: 32'h204, wdata: 32'h11111111, expRdata: 32'hCAFE0204};
      vecs[2] = '{isData: 1'b1, we: 1'b1, addr: 32'h200, wdata: 32'hDEADBEEF, expRdata: 32'hCAFE0204};
      vecs[3] = '{isData: 1'b0, we: 1'b0, addr: 32'h3FC, wdata: 32'h0,        expRdata: 32'hCAFE03FC};
      starvePat = '{32'h280, 32'h280, 32'h280, 32'h280, 32'h180,
                    32'h280, 32'h280, 32'h280, 32'h280, 32'h180};

      reset = 1'b0;
      if_req = 1'b0; if_addr = 32'd0; flush_f = 1'b0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
      #2;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_dm_done", dm_done, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_conflict", conflict_cnt, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tick();

      // Single-requester transactions, zero-wait memory.
      for (int i = 0; i < 4; i++) begin
         logic [31:0] capAddr, capWdata;
         logic        capWe;
         bit          seenReq;
         if (vecs[i].isData) begin
            dm_req = 1'b1; dm_we = vecs[i].we; dm_addr = vecs[i].addr; dm_wdata = vecs[i].wdata;
         end else begin
            if_req = 1'b1; if_addr = vecs[i].addr;
         end
         #1;
         check($sformatf("v%0d_stall_wait", i), vecs[i].isData ? stall_m : stall_f, 1);
         lat = 0; seenReq = 1'b0;
         capAddr = 32'd0; capWdata = 32'd0; capWe = 1'b0;
         while (lat < 20) begin
            tick();
            lat++;
            if (mem_req && !seenReq) begin
               seenReq = 1'b1;
               capAddr = mem_addr; capWe = mem_we; capWdata = mem_wdata;
            end
            if (vecs[i].isData ? dm_done : if_rvalid) break;
         end
         check($sformatf("v%0d_latency", i), 32'(lat), 3);
         check($sformatf("v%0d_mem_addr", i), capAddr, vecs[i].addr);
         check($sformatf("v%0d_mem_we", i), capWe, vecs[i].we);
         if (vecs[i].isData) begin
            check($sformatf("v%0d_mem_wdata", i), capWdata, vecs[i].wdata);
            check($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].expRdata);
            check($sformatf("v%0d_stall_done", i), stall_m, 0);
         end else begin
            check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].expRdata);
            check($sformatf("v%0d_stall_done", i), stall_f, 0);
         end
         if_req = 1'b0; dm_req = 1'b0;
         tick();
      end

      // Simultaneous requests: data first, then fetch.
      start = grantLog.size();
      if_req = 1'b1; if_addr = 32'h104;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
      tick();
      check("both_first_we", mem_we, 1);
      check("both_first_addr", mem_addr, 32'h200);
      check("both_first_wdata", mem_wdata, 32'hDEADBEEF);
      waitPulse(1'b1, cyc);
      check("both_dm_done_seen", 32'(cyc > 0), 1);
      dm_req = 1'b0;
      waitPulse(1'b0, cyc);
      check("both_if_rvalid_seen", 32'(cyc > 0), 1);
      check("both_if_rdata", if_rdata, 32'hCAFE0104);
      check("both_order0", logAt(start), 32'h200);
      check("both_order1", logAt(start + 1), 32'h104);
      if_req = 1'b0;
      tick();

      // Starvation guard: continuous data traffic with a fetch held pending.
      start = grantLog.size();
      stopping = 1'b0;
      if_req = 1'b1; if_addr = 32'h180;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h280;
      for (int c = 0; c < 400 && (if_req || dm_req); c++) begin
         tick();
         if (grantLog.size() >= start + 10) stopping = 1'b1;
         if (stopping && if_rvalid) if_req = 1'b0;
         if (stopping && dm_done) dm_req = 1'b0;
      end
      check("starve_drained", 32'(if_req | dm_req), 0);
      for (int k = 0; k < 10; k++) check($sformatf("starve_grant%0d", k), logAt(start + k), starvePat[k]);
      check("conflict_cnt", conflict_cnt, expConflict);
      tick();

      // Flush while the fetch request is still waiting for a grant.
      start = grantLog.size();
      gntEn = 1'b0;
      if_req = 1'b1; if_addr = 32'h140;
      tick();
      check("flushreq_mem_req", mem_req, 1);
      check("flushreq_mem_addr", mem_addr, 32'h140);
      flush_f = 1'b1;
      #1;
      check("flushreq_stall_f", stall_f, 0);
      tick();
      check("flushreq_withdrawn", mem_req, 0);
      flush_f = 1'b0; if_addr = 32'h150; gntEn = 1'b1;
      waitPulse(1'b0, cyc);
      check("flushreq_if_rvalid_seen", 32'(cyc > 0), 1);
      check("flushreq_if_rdata", if_rdata, 32'hCAFE0150);
      check("flushreq_grants", 32'(grantLog.size() - start), 1);
      check("flushreq_grant_addr", logAt(start), 32'h150);
      if_req = 1'b0;
      tick();

      // Flush while waiting for the response: stale data is discarded.
      start = grantLog.size();
      rspDelay = 4'd2;
      if_req = 1'b1; if_addr = 32'h170;
      tick();
      tick();
      check("flushrsp_in_rsp", mem_req, 0);
      flush_f = 1'b1; if_addr = 32'h160;
      tick();
      flush_f = 1'b0;
      pulses = 0;
      for (int c = 0; c < 40 && grantLog.size() < start + 2; c++) begin
         if (if_rvalid) pulses++;
         tick();
      end
      check("flushrsp_stale_pulses", 32'(pulses), 0);
      waitPulse(1'b0, cyc);
      check("flushrsp_if_rvalid_seen", 32'(cyc > 0), 1);
      check("flushrsp_if_rdata", if_rdata, 32'hCAFE0160);
      check("flushrsp_grant0", logAt(start), 32'h170);
      check("flushrsp_grant1", logAt(start + 1), 32'h160);
      if_req = 1'b0;
      rspDelay = 4'd0;
      tick();

      // Asynchronous reset in the middle of a data response.
      rspDelay = 4'd3;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h220;
      tick();
      tick();
      check("rstmid_addr_before", mem_addr, 32'h220);
      #2;
      reset = 1'b0; dm_req = 1'b0;
      #1;
      check("rstmid_mem_req", mem_req, 0);
      check("rstmid_mem_addr", mem_addr, 0);
      check("rstmid_mem_wdata", mem_wdata, 0);
      check("rstmid_if_rdata", if_rdata, 0);
      check("rstmid_dm_rdata", dm_rdata, 0);
      check("rstmid_dm_done", dm_done, 0);
      check("rstmid_stall_m", stall_m, 0);
      rspDelay = 4'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tick();
      start = grantLog.size();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h230; dm_wdata = 32'h12345678;
      tick();
      check("postrst_mem_addr", mem_addr, 32'h230);
      check("postrst_mem_we", mem_we, 1);
      waitPulse(1'b1, cyc);
      check("postrst_latency", 32'(cyc), 2);
      check("postrst_grant", logAt(start), 32'h230);
      dm_req = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
